// File: rtl/sha_block_builder.sv
// Packs a stream of 16-bit big-endian message words into 512-bit SHA blocks,
// appends the 0x8000 pad marker and 64-bit bit length, and handshakes each block with the hash core.
module sha_block_builder (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [15:0]  wdata,
  input  logic         last,
  input  logic         done,
  output logic         ready,
  output logic [511:0] block,
  output logic         start,
  output logic         first,
  output logic         msg_done
);

  typedef enum logic [2:0] {FILL, PAD, ISSUE, WAIT, LENBLK} state_e;

  state_e      state_q, state_d;
  logic [15:0] words_q [32];
  logic [15:0] words_d [32];
  logic [4:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic        len_pending_q, len_pending_d;
  logic        pad0_q, pad0_d;
  logic        final_q, final_d;
  logic        issued_q, issued_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        first_q, first_d;
  logic        msg_done_q, msg_done_d;
  logic [63:0] len_bits;

  assign len_bits = {36'd0, cnt_q, 4'd0};

  for (genvar g = 0; g < 32; g++) begin : g_block
    assign block[511-16*g -: 16] = words_q[g];
  end

  assign ready    = (state_q == FILL);
  assign start    = start_q;
  assign first    = first_q;
  assign msg_done = msg_done_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a latch behind.
    state_d       = state_q;
    words_d       = words_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    len_pending_d = len_pending_q;
    pad0_d        = pad0_q;
    final_d       = final_q;
    issued_d      = issued_q;
    done_d        = done;
    msg_done_d    = 1'b0;

    case (state_q)
      FILL: begin
        if (wr) begin
          words_d[idx_q] = wdata;
          idx_d          = idx_q + 5'd1;
          cnt_d          = cnt_q + 24'd1;
          if (last)                 state_d = PAD;
          else if (idx_q == 5'd31)  state_d = ISSUE;
        end
      end
      PAD: begin
        // idx wrapped to 0: the block is all data, so the pad marker rides in the length block.
        if (idx_q == 5'd0) begin
          len_pending_d = 1'b1;
          pad0_d        = 1'b1;
        end else begin
          for (int i = 0; i < 32; i++)
            if (5'(i) > idx_q) words_d[5'(i)] = '0;
          words_d[idx_q] = 16'h8000;
          if (idx_q <= 5'd27) begin
            words_d[28] = len_bits[63:48];
            words_d[29] = len_bits[47:32];
            words_d[30] = len_bits[31:16];
            words_d[31] = len_bits[15:0];
            final_d     = 1'b1;
          end else begin
            len_pending_d = 1'b1;
          end
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        issued_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (done && !done_q) begin
          if (len_pending_q) begin
            state_d = LENBLK;
          end else if (final_q) begin
            msg_done_d = 1'b1;
            cnt_d      = '0;
            idx_d      = '0;
            issued_d   = 1'b0;
            final_d    = 1'b0;
            state_d    = FILL;
          end else begin
            idx_d   = '0;
            state_d = FILL;
          end
        end
      end
      LENBLK: begin
        for (int i = 0; i < 28; i++) words_d[5'(i)] = '0;
        if (pad0_q) words_d[0] = 16'h8000;
        words_d[28]   = len_bits[63:48];
        words_d[29]   = len_bits[47:32];
        words_d[30]   = len_bits[31:16];
        words_d[31]   = len_bits[15:0];
        len_pending_d = 1'b0;
        pad0_d        = 1'b0;
        final_d       = 1'b1;
        state_d       = ISSUE;
      end
      default: state_d = FILL;
    endcase

    start_d = (state_d == ISSUE);
    first_d = (state_d == ISSUE) && !issued_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      // NOTE: the block store is reset too, because block must read as zero out of reset.
      for (int i = 0; i < 32; i++) words_q[i] <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      len_pending_q <= 1'b0;
      pad0_q        <= 1'b0;
      final_q       <= 1'b0;
      issued_q      <= 1'b0;
      done_q        <= 1'b0;
      start_q       <= 1'b0;
      first_q       <= 1'b0;
      msg_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q       <= state_d;
      words_q       <= words_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      len_pending_q <= len_pending_d;
      pad0_q        <= pad0_d;
      final_q       <= final_d;
      issued_q      <= issued_d;
      done_q        <= done_d;
      start_q       <= start_d;
      first_q       <= first_d;
      msg_done_q    <= msg_done_d;
    end
  end

endmodule

// File: tb/tb_sha_block_builder.sv
// Randomized bench for sha_block_builder: a word-level SHA padding model predicts every block,
// plus directed length, done-edge and reset scenarios.
module tb_sha_block_builder;

  logic         clk;
  logic         reset;
  logic         wr;
  logic [15:0]  wdata;
  logic         last;
  logic         done;
  logic         ready;
  logic [511:0] block;
  logic         start;
  logic         first;
  logic         msg_done;

  logic [15:0]  msg_q [$];
  logic [511:0] exp_q [$];
  logic [511:0] got_q [$];
  int n_vec;
  int n_mis;

  sha_block_builder dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .wdata    (wdata),
    .last     (last),
    .done     (done),
    .ready    (ready),
    .block    (block),
    .start    (start),
    .first    (first),
    .msg_done (msg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] wd(input logic [511:0] b, input int j);
    return b[511-16*j -: 16];
  endfunction

  // Standard SHA padding on 16-bit words: marker, zeros to 28 mod 32, then 64-bit bit count.
  function automatic void build_expected();
    logic [15:0]  w [$];
    logic [63:0]  bits;
    logic [511:0] blk;
    w = msg_q;
    w.push_back(16'h8000);
    while (w.size() % 32 != 28) w.push_back(16'h0000);
    bits = 64'(msg_q.size()) * 64'd16;
    w.push_back(bits[63:48]);
    w.push_back(bits[47:32]);
    w.push_back(bits[31:16]);
    w.push_back(bits[15:0]);
    exp_q.delete();
    for (int b = 0; b < w.size() / 32; b++) begin
      blk = '0;
      for (int j = 0; j < 32; j++) blk[511-16*j -: 16] = w[32*b+j];
      exp_q.push_back(blk);
    end
  endfunction

  task automatic set_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(16'($urandom));
  endtask

  // Streams msg_q into the DUT, answers each start with a delayed done, and checks every block.
  task automatic run_msg(input int junk_pct, input int abort_at);
    int n, widx, bidx, iter, exp_start_iter, dly, hold;
    bit pend, finished;
    n = msg_q.size();
    widx = 0; bidx = 0; iter = 0; exp_start_iter = -1; dly = 0; hold = 0;
    pend = 1'b0; finished = 1'b0;
    build_expected();
    got_q.delete();
    while (!finished && iter < 3000) begin
      @(negedge clk);
      if (start) begin
        n_vec++;
        if (bidx >= exp_q.size()) begin
          n_mis++;
          $display("FAIL extra_start: got start for block %0d, required only %0d blocks", bidx, exp_q.size());
        end else begin
          if (block !== exp_q[bidx]) begin
            n_mis++;
            $display("FAIL block_%0d: got %h required %h", bidx, block, exp_q[bidx]);
          end
          n_vec++;
          if (first !== (bidx == 0)) begin
            n_mis++;
            $display("FAIL first_%0d: got %b required %b", bidx, first, (bidx == 0));
          end
        end
        if (exp_start_iter >= 0) begin
          n_vec++;
          if (iter !== exp_start_iter) begin
            n_mis++;
            $display("FAIL start_latency: got cycle %0d required cycle %0d", iter, exp_start_iter);
          end
          exp_start_iter = -1;
        end
        got_q.push_back(block);
        bidx++;
        if (abort_at > 0 && bidx == abort_at) begin
          wr = 1'b0; last = 1'b0; done = 1'b0;
          return;
        end
        pend = 1'b1;
        dly  = $urandom_range(1, 3);
      end
      if (msg_done) begin
        n_vec++;
        if (bidx !== exp_q.size() || widx !== n) begin
          n_mis++;
          $display("FAIL msg_done_early: got after %0d blocks/%0d words, required %0d blocks/%0d words",
                   bidx, widx, exp_q.size(), n);
        end
        finished = 1'b1;
      end
      if (done) begin
        if (hold == 0) done = 1'b0;
        else hold--;
      end else if (pend) begin
        if (dly == 0) begin
          done = 1'b1;
          hold = $urandom_range(0, 2);
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      wr = 1'b0; last = 1'b0; wdata = 16'($urandom);
      if (ready && widx < n) begin
        if ($urandom_range(0, 99) >= 20) begin
          wr = 1'b1;
          wdata = msg_q[widx];
          last = (widx == n - 1);
          if (last) exp_start_iter = iter + 2;
          else if (widx % 32 == 31) exp_start_iter = iter + 1;
          widx++;
        end else begin
          last = 1'($urandom_range(0, 1));
        end
      end else if (!ready && $urandom_range(0, 99) < junk_pct) begin
        wr = 1'b1;
        last = 1'($urandom_range(0, 1));
      end
      iter++;
    end
    if (!finished) begin
      n_vec++; n_mis++;
      $display("FAIL timeout: got %0d blocks/%0d words without msg_done, required %0d blocks", bidx, widx, exp_q.size());
    end
    wr = 1'b0; last = 1'b0;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || start !== 1'b0 || first !== 1'b0 || msg_done !== 1'b0 || block !== '0) begin
      n_mis++;
      $display("FAIL reset_hold: got ready=%b start=%b first=%b msg_done=%b block_zero=%b required 1 0 0 0 1",
               ready, start, first, msg_done, (block === '0));
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || start !== 1'b0 || first !== 1'b0 || msg_done !== 1'b0 || block !== '0) begin
      n_mis++;
      $display("FAIL reset_release: got ready=%b start=%b first=%b msg_done=%b block_zero=%b required 1 0 0 0 1",
               ready, start, first, msg_done, (block === '0));
    end
  endtask

  task automatic test_single_word();
    msg_q.delete();
    msg_q.push_back(16'hABCD);
    run_msg(20, 0);
    n_vec++;
    if (got_q.size() !== 1) begin
      n_mis++;
      $display("FAIL single_count: got %0d starts required 1", got_q.size());
    end else begin
      n_vec++;
      if (got_q[0] !== {16'hABCD, 16'h8000, 464'd0, 16'h0010}) begin
        n_mis++;
        $display("FAIL single_block: got %h required abcd8000..0010", got_q[0]);
      end
    end
  endtask

  task automatic test_27();
    set_msg(27);
    run_msg(20, 0);
    n_vec++;
    if (got_q.size() !== 1) begin
      n_mis++;
      $display("FAIL w27_count: got %0d starts required 1", got_q.size());
    end else begin
      n_vec++;
      if (wd(got_q[0], 27) !== 16'h8000 || got_q[0][63:0] !== 64'h0000_0000_0000_01B0) begin
        n_mis++;
        $display("FAIL w27_tail: got w27=%h len=%h required 8000 00000000000001b0", wd(got_q[0], 27), got_q[0][63:0]);
      end
    end
  endtask

  task automatic test_28();
    set_msg(28);
    run_msg(20, 0);
    n_vec++;
    if (got_q.size() !== 2) begin
      n_mis++;
      $display("FAIL w28_count: got %0d starts required 2", got_q.size());
    end else begin
      n_vec++;
      if (got_q[0][63:0] !== 64'h8000_0000_0000_0000 || got_q[1] !== {496'd0, 16'h01C0}) begin
        n_mis++;
        $display("FAIL w28_blocks: got tail1=%h block2=%h required 8000000000000000 0..01c0", got_q[0][63:0], got_q[1]);
      end
    end
  endtask

  task automatic test_32();
    set_msg(32);
    run_msg(20, 0);
    n_vec++;
    if (got_q.size() !== 2) begin
      n_mis++;
      $display("FAIL w32_count: got %0d starts required 2", got_q.size());
    end else begin
      n_vec++;
      if (got_q[1] !== {16'h8000, 480'd0, 16'h0200}) begin
        n_mis++;
        $display("FAIL w32_block2: got %h required 8000..0200", got_q[1]);
      end
    end
  endtask

  task automatic test_wr_in_wait();
    set_msg(45);
    run_msg(90, 0);
  endtask

  task automatic test_done_held();
    set_msg(1);
    build_expected();
    done = 1'b1;
    @(negedge clk);
    wr = 1'b1; last = 1'b1; wdata = msg_q[0];
    @(negedge clk);
    wr = 1'b0; last = 1'b0;
    @(negedge clk);
    n_vec++;
    if (start !== 1'b1 || first !== 1'b1 || block !== exp_q[0]) begin
      n_mis++;
      $display("FAIL held_start: got start=%b first=%b block=%h required 1 1 %h", start, first, block, exp_q[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b0 || msg_done !== 1'b0 || start !== 1'b0) begin
        n_mis++;
        $display("FAIL held_no_advance: got ready=%b msg_done=%b start=%b required 0 0 0", ready, msg_done, start);
      end
    end
    done = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    n_vec++;
    if (msg_done !== 1'b1) begin
      n_mis++;
      $display("FAIL held_msg_done: got %b required 1", msg_done);
    end
    done = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || msg_done !== 1'b0) begin
      n_mis++;
      $display("FAIL held_back_to_fill: got ready=%b msg_done=%b required 1 0", ready, msg_done);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_msg(28);
    run_msg(0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || start !== 1'b0 || first !== 1'b0 || msg_done !== 1'b0 || block !== '0) begin
      n_mis++;
      $display("FAIL midwait_reset: got ready=%b start=%b first=%b msg_done=%b block_zero=%b required 1 0 0 0 1",
               ready, start, first, msg_done, (block === '0));
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || start !== 1'b0 || first !== 1'b0 || msg_done !== 1'b0 || block !== '0) begin
      n_mis++;
      $display("FAIL midwait_release: got ready=%b start=%b first=%b msg_done=%b block_zero=%b required 1 0 0 0 1",
               ready, start, first, msg_done, (block === '0));
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (start !== 1'b0 || msg_done !== 1'b0 || ready !== 1'b1) begin
        n_mis++;
        $display("FAIL midwait_abandon: got start=%b msg_done=%b ready=%b required 0 0 1", start, msg_done, ready);
      end
    end
    test_single_word();
  endtask

  task automatic test_random();
    for (int m = 0; m < 10; m++) begin
      set_msg($urandom_range(1, 70));
      run_msg(30, 0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    reset = 1'b1;
    wr    = 1'b0;
    last  = 1'b0;
    done  = 1'b0;
    wdata = '0;
    test_reset();
    test_single_word();
    test_27();
    test_28();
    test_32();
    test_wr_in_wait();
    test_done_held();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
